// File: rtl/mli_digit_sequencer.sv
//------------------------------------------------------------------------------
// Module  : mli_digit_sequencer
// Brief   : Prescaled tick, up/down digit counter and registered 7-seg decode.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mli_digit_sequencer #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter logic [3:0]  DIGIT_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       run,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       tick,
  output logic [3:0] digit,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [23:0] c_PRESC_LAST = MAX_COUNT - 24'd1;

  logic [23:0] r_presc;
  logic        r_tick;
  logic [3:0]  r_digit;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic        r_load_q;

  logic        w_load_edge;
  logic [3:0]  w_load_clamp;
  logic [3:0]  w_digit_step;
  logic [6:0]  w_seg;

  assign w_load_edge  = load & ~r_load_q;
  assign w_load_clamp = (load_val > DIGIT_MAX) ? DIGIT_MAX : load_val;

  always_comb begin
    w_digit_step = r_digit;
    if (dir) begin
      w_digit_step = (r_digit == DIGIT_MAX) ? 4'd0 : r_digit + 4'd1;
    end else begin
      w_digit_step = (r_digit == 4'd0) ? DIGIT_MAX : r_digit - 4'd1;
    end
  end

  // Segment order {g,f,e,d,c,b,a}, active-high
  always_comb begin
    w_seg = 7'h3F;
    case (r_digit)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      default: w_seg = 7'h71;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc  <= 24'd0;
      r_tick   <= 1'b0;
      r_digit  <= 4'd0;
      r_seg    <= 7'h3F;
      r_dp     <= 1'b0;
      r_load_q <= 1'b0;
    end else if (en) begin
      r_load_q <= load;
      r_seg    <= w_seg;
      // A load edge restarts the period and pre-empts any pending step
      if (w_load_edge) begin
        r_presc <= 24'd0;
        r_tick  <= 1'b0;
        r_digit <= w_load_clamp;
      end else begin
        if (run) begin
          if (r_presc == c_PRESC_LAST) begin
            r_presc <= 24'd0;
            r_tick  <= 1'b1;
          end else begin
            r_presc <= r_presc + 24'd1;
            r_tick  <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
        end
        if (r_tick) begin
          r_digit <= w_digit_step;
        end
      end
      if (r_tick) begin
        r_dp <= ~r_dp;
      end
    end
  end

  assign tick  = r_tick;
  assign digit = r_digit;
  assign seg   = r_seg;
  assign dp    = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_mli_digit_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_mli_digit_sequencer
// Brief   : Directed bench for decimal and hex instances against a cycle model.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mli_digit_sequencer;

  localparam int c_MC = 4;

  logic       clk = 1'b0;
  logic       rst, en, run, dir, load;
  logic [3:0] load_val;

  logic       dec_tick, hex_tick, dec_dp, hex_dp;
  logic [3:0] dec_digit, hex_digit;
  logic [6:0] dec_seg, hex_seg;

  int checks   = 0;
  int failures = 0;

  // Model state, index 0 = decimal instance, 1 = hex instance
  int  m_cnt[2];
  int  m_tick[2];
  int  m_digit[2];
  int  m_seg[2];
  int  m_dp[2];
  int  m_lq[2];
  bit  m_valid = 1'b0;
  int  seg_tbl[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  always #5 clk = ~clk;

  mli_digit_sequencer #(.MAX_COUNT(24'd4), .DIGIT_MAX(4'd9)) u_dec (
    .clk(clk), .rst(rst), .en(en), .run(run), .dir(dir), .load(load),
    .load_val(load_val), .tick(dec_tick), .digit(dec_digit), .seg(dec_seg),
    .dp(dec_dp)
  );

  mli_digit_sequencer #(.MAX_COUNT(24'd4), .DIGIT_MAX(4'd15)) u_hex (
    .clk(clk), .rst(rst), .en(en), .run(run), .dir(dir), .load(load),
    .load_val(load_val), .tick(hex_tick), .digit(hex_digit), .seg(hex_seg),
    .dp(hex_dp)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next state from the rules, using values from before the edge
  task automatic model_upd(input int k, input int dmax);
    int  old_tick;
    bit  ld_edge;
    old_tick = m_tick[k];
    ld_edge  = load && (m_lq[k] == 0);
    if (rst) begin
      m_cnt[k] = 0; m_tick[k] = 0; m_digit[k] = 0;
      m_seg[k] = 'h3F; m_dp[k] = 0; m_lq[k] = 0;
    end else if (en) begin
      m_seg[k] = seg_tbl[m_digit[k]];
      if (old_tick != 0) m_dp[k] = 1 - m_dp[k];
      if (ld_edge) begin
        m_digit[k] = (int'(load_val) > dmax) ? dmax : int'(load_val);
        m_cnt[k]   = 0;
        m_tick[k]  = 0;
      end else begin
        if (old_tick != 0) begin
          if (dir) m_digit[k] = (m_digit[k] + 1) % (dmax + 1);
          else     m_digit[k] = (m_digit[k] + dmax) % (dmax + 1);
        end
        if (run) begin
          m_cnt[k]  = (m_cnt[k] + 1) % c_MC;
          m_tick[k] = (m_cnt[k] == 0) ? 1 : 0;
        end else begin
          m_tick[k] = 0;
        end
      end
      m_lq[k] = load ? 1 : 0;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) m_valid = 1'b1;
      model_upd(0, 9);
      model_upd(1, 15);
      #1;
      if (m_valid) begin
        chk("dec_tick",  int'(dec_tick),  m_tick[0]);
        chk("dec_digit", int'(dec_digit), m_digit[0]);
        chk("dec_seg",   int'(dec_seg),   m_seg[0]);
        chk("dec_dp",    int'(dec_dp),    m_dp[0]);
        chk("hex_tick",  int'(hex_tick),  m_tick[1]);
        chk("hex_digit", int'(hex_digit), m_digit[1]);
        chk("hex_seg",   int'(hex_seg),   m_seg[1]);
        chk("hex_dp",    int'(hex_dp),    m_dp[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; run = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'd0;
    #2;
    cyc(2);
    chk("rst_digit", int'(dec_digit), 0);
    chk("rst_seg",   int'(dec_seg), 'h3F);
    chk("rst_tick",  int'(dec_tick), 0);
    chk("rst_dp",    int'(dec_dp), 0);

    // Count up through a full decimal wrap
    rst = 1'b0; en = 1'b1; run = 1'b1; dir = 1'b1;
    cyc(3);  chk("no_early_tick", int'(dec_tick), 0);
    cyc(1);  chk("first_tick", int'(dec_tick), 1);
    cyc(1);  chk("digit_1", int'(dec_digit), 1); chk("dp_1", int'(dec_dp), 1);
    cyc(1);  chk("seg_1", int'(dec_seg), 'h06);
    cyc(35); chk("dec_wrap", int'(dec_digit), 0); chk("hex_10", int'(hex_digit), 10);
    chk("dp_even", int'(dec_dp), 0);

    // Count down from zero
    dir = 1'b0;
    cyc(4);  chk("down_9", int'(dec_digit), 9); chk("hex_down_9", int'(hex_digit), 9);
    cyc(1);  chk("seg_9", int'(dec_seg), 'h6F);
    cyc(3);  chk("down_8", int'(dec_digit), 8);
    cyc(1);  chk("seg_8", int'(dec_seg), 'h7F);

    // Load with clamp, prescaler restart
    load = 1'b1; load_val = 4'd12;
    cyc(1);  chk("load_clamp", int'(dec_digit), 9); chk("hex_load_12", int'(hex_digit), 12);
    cyc(3);  chk("restart_no_tick", int'(dec_tick), 0);
    cyc(1);  chk("restart_tick", int'(dec_tick), 1);
    load = 1'b0;
    cyc(1);  chk("after_load_down", int'(dec_digit), 8);
    load = 1'b1; load_val = 4'd5;
    cyc(1);  chk("load_5", int'(dec_digit), 5);
    cyc(1);  chk("seg_5", int'(dec_seg), 'h6D);

    // Load edge coincident with tick
    load = 1'b0;
    cyc(1);
    load = 1'b1; load_val = 4'd3;
    cyc(1);  chk("load_3", int'(dec_digit), 3);
    load = 1'b0; dir = 1'b1;
    cyc(3);
    cyc(1);  chk("coinc_tick", int'(dec_tick), 1);
    load = 1'b1; load_val = 4'd7;
    cyc(1);  chk("load_wins", int'(dec_digit), 7); chk("hex_load_wins", int'(hex_digit), 7);

    // Pause mid-period
    load = 1'b0;
    cyc(2);
    run = 1'b0;
    cyc(10); chk("pause_tick", int'(dec_tick), 0); chk("pause_digit", int'(dec_digit), 7);
    run = 1'b1;
    cyc(1);  chk("resume_no_tick", int'(dec_tick), 0);
    cyc(1);  chk("resume_tick", int'(dec_tick), 1);
    cyc(1);  chk("resume_step", int'(dec_digit), 8);

    // Disabled: load edge ignored, state frozen
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    cyc(5);  chk("en0_digit", int'(dec_digit), 8);
    load = 1'b0;
    cyc(1);
    en = 1'b1;
    cyc(2);  chk("en1_digit", int'(dec_digit), 8);

    // Hex wrap E -> F -> 0
    load = 1'b1; load_val = 4'd14;
    cyc(1);  chk("hex_load_e", int'(hex_digit), 14); chk("dec_load_e", int'(dec_digit), 9);
    cyc(1);  chk("hex_seg_e", int'(hex_seg), 'h79);
    load = 1'b0;
    cyc(3);  chk("hex_tick_e", int'(hex_tick), 1);
    cyc(1);  chk("hex_f", int'(hex_digit), 15);
    cyc(1);  chk("hex_seg_f", int'(hex_seg), 'h71);
    cyc(3);  chk("hex_0", int'(hex_digit), 0);
    cyc(1);  chk("hex_seg_0", int'(hex_seg), 'h3F);

    // Reset mid-run
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_digit", int'(hex_digit), 0);
    chk("mid_rst_seg",   int'(hex_seg), 'h3F);
    chk("mid_rst_tick",  int'(hex_tick), 0);
    chk("mid_rst_dp",    int'(dec_dp), 0);
    rst = 1'b0;
    cyc(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
